life_engine: RTL
================

# life_engine

Parametrised Conway's Game of Life engine; successor to the fixed 16x16 `datapath`. It holds a ROWS x COLS cell grid in registers and loads it from a seed. It advances the grid one generation per clock under run/step control, with selectable toroidal or dead-edge boundaries. It counts generations and halts itself on stability, extinction or a generation limit. It sits between the seed source and the display/logging path.

## Interface
- ROWS, 16, grid height (>=3)
- COLS, 16, grid width (>=3)
- GEN_W, 16, generation counter width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- seed  in  ROWS*COLS  initial pattern; cell (r,c) = bit r*COLS+c (row 0 = bits [COLS-1:0])
- load  in  1  pulse: copy seed into grid
- run  in  1  level: free-run one generation per cycle
- step  in  1  pulse: advance exactly one generation while not running
- wrap  in  1  1 = toroidal neighbours, 0 = cells beyond edges are dead
- max_gen  in  GEN_W  halt after this many generations; 0 = unlimited
- grid  out  ROWS*COLS  current generation, registered
- gen_count  out  GEN_W  generations since last load
- stable  out  1  last update produced no change
- extinct  out  1  grid is all zero
- done  out  1  engine in HALT

## Operation
- Rule B3/S23: a live cell survives with 2 or 3 live neighbours; a dead cell is born with exactly 3. Eight-neighbour Moore count, 4-bit.
- The next grid is combinational from the registered grid and `wrap`. `wrap` is sampled every cycle.
- States: IDLE, RUN, HALT. Input priority each cycle: load > run > step.
- IDLE:
  - load: grid<=seed; gen_count, stable and done cleared; extinct<=(seed==0). Stay in IDLE.
  - run=1: update the grid this edge, go to RUN.
  - step=1: one update, stay in IDLE.
- RUN, run=1: grid<=next; gen_count++.
- RUN, run=0: no update, go to IDLE.
- Halt condition, evaluated on the update edge: next==grid (stable<=1), next==0 (extinct<=1), gen_count+1==max_gen with max_gen!=0, or gen_count+1 saturating at all-ones. The update still commits; the state goes to HALT.
- Halt from a step in IDLE goes to HALT the same way.
- HALT: grid frozen; run and step ignored; done=1. load performs the IDLE load and returns to IDLE.
- An update from an all-zero grid is an extinct halt with gen_count incremented.

## Timing
- Reset value of every output is 0; state is IDLE.
- Reset acts asynchronously mid-operation and discards any update in flight.
- Latency: the grid changes on the same rising edge that samples run=1 or step=1. Flags and done are valid in the same cycle as the new grid.
- A step pulse held for N cycles in IDLE gives N generations; the bench drives 1-cycle pulses.
- load while run=1 takes precedence; RUN begins on the following edge.
- A change to max_gen takes effect on the next compare.

## Structure
- life_pkg: state_t enum {IDLE, RUN, HALT}; constants BIRTH=3, SURV_LO=2, SURV_HI=3; function idx(r,c) returning r*COLS+c.
- Sub-module life_cell: combinational, 8 neighbour bits + self in, next state out. It is instantiated ROWS*COLS times by generate, with the neighbour index selection (wrap vs dead edge) done in life_engine.
- life_engine owns the FSM, grid register, counter and flags.

## Test plan
- Blinker: seed=256'h0000e00000 (row 1, cols 5-7), wrap=0, run=1 → gen 1 grid has bits 6, 22, 38 set. Gen 2 returns to the seed. stable=0 throughout; gen_count increments each cycle.
- Block: seed bits 17, 18, 33, 34, run=1 → after 1 edge grid is unchanged, stable=1, done=1, gen_count=1. Later run/step pulses cause no change.
- Boundary: seed bits 15, 0, 1 (row 0 horizontal across the edge).
  - wrap=1, step → bits 240, 0, 16 set.
  - Same seed, wrap=0, step → grid=0, extinct=1, done=1.
- Limit: blinker seed, max_gen=4, run held → HALT with gen_count=4 and the grid equal to the seed. load then returns to IDLE with gen_count=0.
- Pause/step: blinker running; run=0 at gen 3 → grid frozen for 5 cycles. One step pulse → gen_count=4, one phase flip.
- Async reset: reset low mid-RUN between edges → grid=0, gen_count=0, done=0 immediately. After release, the engine stays in IDLE until load/run.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types, rule constants and grid index helper for the Game of Life engine.
package life_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [3:0] BIRTH   = 4'd3;
  localparam logic [3:0] SURV_LO = 4'd2;
  localparam logic [3:0] SURV_HI = 4'd3;

  // Neighbour offsets; order is NW, N, NE, W, E, SW, S, SE.
  localparam int NBR_DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  localparam int NBR_DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell.sv
// One Game of Life cell: Moore neighbour count and B3/S23 next-state rule.
module life_cell
  import life_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       alive,
  output logic       alive_next
);

  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, nbr[i]};
    end
    alive_next = (cnt == BIRTH) || (alive && (cnt >= SURV_LO) && (cnt <= SURV_HI));
  end

endmodule

// File: rtl/life_engine.sv
// Registered ROWS x COLS Game of Life grid with run/step control, generation counter and
// self-halting on stability, extinction or a generation limit.
module life_engine
  import life_pkg::*;
#(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 load,
  input  logic                 run,
  input  logic                 step,
  input  logic                 wrap,
  input  logic [GEN_W-1:0]     max_gen,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 extinct,
  output logic                 done
);

  localparam int N      = int'(ROWS * COLS);
  localparam int ROWS_I = int'(ROWS);
  localparam int COLS_I = int'(COLS);

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d, next_grid;
  logic [GEN_W-1:0] gen_q, gen_d, gen_inc;
  logic             stable_q, stable_d, extinct_q, extinct_d;
  logic             upd, halt;

  for (genvar r = 0; r < ROWS_I; r++) begin : g_row
    for (genvar c = 0; c < COLS_I; c++) begin : g_col
      logic [7:0] nbr;
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int  RR     = r + NBR_DR[k];
        localparam int  CC     = c + NBR_DC[k];
        localparam bit  INSIDE = (RR >= 0) && (RR < ROWS_I) && (CC >= 0) && (CC < COLS_I);
        localparam int  NI     = idx((RR + ROWS_I) % ROWS_I, (CC + COLS_I) % COLS_I, COLS_I);
        // Off-grid neighbours exist only when the torus is closed.
        if (INSIDE) begin : g_in
          assign nbr[k] = grid_q[NI];
        end else begin : g_edge
          assign nbr[k] = wrap & grid_q[NI];
        end
      end
      life_cell u_cell (
        .nbr       (nbr),
        .alive     (grid_q[idx(r, c, COLS_I)]),
        .alive_next(next_grid[idx(r, c, COLS_I)])
      );
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    upd       = 1'b0;
    gen_inc   = gen_q + GEN_W'(1'b1);
    halt      = (next_grid == grid_q) || (next_grid == '0) ||
                ((max_gen != '0) && (gen_inc == max_gen)) || (gen_inc == '1);
    if (load) begin
      grid_d    = seed;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = (seed == '0);
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) begin
            upd     = 1'b1;
            state_d = RUN;
          end else if (step) begin
            upd = 1'b1;
          end
        end
        RUN: begin
          if (run) upd = 1'b1;
          else state_d = IDLE;
        end
        HALT:    ;
        default: state_d = IDLE;
      endcase
      if (upd) begin
        grid_d    = next_grid;
        gen_d     = gen_inc;
        stable_d  = (next_grid == grid_q);
        extinct_d = (next_grid == '0);
        if (halt) state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign done      = (state_q == HALT);

endmodule
